// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : FSM encodings, config-word layout, reset defaults and
//               word-size limits for the buffered UART transmitter.
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    localparam int ST_W = 6;
    localparam logic [ST_W-1:0] ST_IDLE   = 6'b000001;
    localparam logic [ST_W-1:0] ST_LOAD   = 6'b000010;
    localparam logic [ST_W-1:0] ST_START  = 6'b000100;
    localparam logic [ST_W-1:0] ST_DATA   = 6'b001000;
    localparam logic [ST_W-1:0] ST_PARITY = 6'b010000;
    localparam logic [ST_W-1:0] ST_STOP   = 6'b100000;

    localparam int CFG_STORE   = 0;
    localparam int CFG_WS_LSB  = 1;
    localparam int CFG_WS_MSB  = 4;
    localparam int CFG_PAR_EN  = 5;
    localparam int CFG_NSTOP   = 6;
    localparam int CFG_PAR_ODD = 7;

    localparam int WS_W = 4;
    localparam logic [WS_W-1:0] WS_MIN = 4'd5;
    localparam logic [WS_W-1:0] DEF_WS = 4'd8;
    localparam logic DEF_PAR_EN  = 1'b1;
    localparam logic DEF_PAR_ODD = 1'b0;
    localparam logic DEF_NSTOP   = 1'b0;

    typedef struct packed {
        logic [WS_W-1:0] ws;
        logic            par_en;
        logic            n_stop;
        logic            par_odd;
    } cfg_t;

    function automatic logic [WS_W-1:0] clamp_ws(input logic [WS_W-1:0] ws,
                                                 input logic [WS_W-1:0] ws_max);
        if (ws < WS_MIN)
            return WS_MIN;
        else if (ws > ws_max)
            return ws_max;
        else
            return ws;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_checker.sv
`default_nettype none
// ============================================================================
// Module      : parity_checker
// Description : Even/odd parity of a data word (XOR reduction, optionally
//               inverted for odd parity).
// Revision    : 1.0
// ============================================================================
module parity_checker #(
    parameter int WORD_SIZE = 8
) (
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_odd,
    output logic                 o_parity
);

    assign o_parity = (^i_data) ^ i_odd;

endmodule
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous FIFO with registered occupancy count; pushes when
//               full and pops when empty are ignored.
// Revision    : 1.0
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push)
            mem_q[wr_ptr_q] <= i_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : UART transmitter with TX FIFO, runtime word size, parity and
//               stop-bit configuration, and a sticky overflow flag.
// Revision    : 1.0
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_config,
    input  logic [DATA_W-1:0]             i_tx_parallel,
    input  logic                          i_tx_valid,
    input  logic                          i_clear_overflow,
    input  logic                          i_uart_clk_enable,
    output logic                          o_tx,
    output logic                          o_ready,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow
);

    localparam logic [WS_W-1:0] c_ws_max = WS_W'(DATA_W);
    localparam logic [WS_W-1:0] c_ws_rst = (c_ws_max < DEF_WS) ? c_ws_max : DEF_WS;

    logic [ST_W-1:0]   state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic              overflow_q, overflow_d;
    logic              tx_q;
    logic [DATA_W-1:0] shift_q;
    logic [WS_W-1:0]   idx_q;
    logic              stop_q;
    logic              parity_q;
    logic [WS_W-1:0]   frame_ws_q;
    logic              frame_par_en_q;
    logic              frame_nstop_q;

    logic              w_full, w_empty, w_push, w_pop, w_store, w_parity;
    logic [DATA_W-1:0] w_push_data, w_head;

    assign o_tx       = tx_q;
    assign o_ready    = !w_full;
    assign o_overflow = overflow_q;
    assign w_push     = i_tx_valid && !w_full;
    assign w_store    = i_config[CFG_STORE] && (state_q == ST_IDLE) && w_empty;

    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < DATA_W; i++)
            w_push_data[i] = i_tx_parallel[i] & (WS_W'(i) < cfg_q.ws);
    end

    uart_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_count)
    );

    parity_checker #(
        .WORD_SIZE (DATA_W)
    ) u_parity (
        .i_data   (w_head),
        .i_odd    (cfg_q.par_odd),
        .o_parity (w_parity)
    );

    always_comb begin
        cfg_d = cfg_q;
        if (w_store) begin
            cfg_d.ws      = clamp_ws(i_config[CFG_WS_MSB:CFG_WS_LSB], c_ws_max);
            cfg_d.par_en  = i_config[CFG_PAR_EN];
            cfg_d.n_stop  = i_config[CFG_NSTOP];
            cfg_d.par_odd = i_config[CFG_PAR_ODD];
        end
    end

    // A new drop takes priority over a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (i_tx_valid && w_full)
            overflow_d = 1'b1;
        else if (i_clear_overflow)
            overflow_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cfg_q      <= '{ws: c_ws_rst, par_en: DEF_PAR_EN, n_stop: DEF_NSTOP, par_odd: DEF_PAR_ODD};
            overflow_q <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!w_empty) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  if (i_uart_clk_enable) state_d = ST_DATA;
            ST_DATA:   if (i_uart_clk_enable && (idx_q == frame_ws_q - 1'b1))
                           state_d = frame_par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (i_uart_clk_enable) state_d = ST_STOP;
            ST_STOP:   if (i_uart_clk_enable && (stop_q == frame_nstop_q))
                           state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q != ST_IDLE);
        w_pop  = (state_q == ST_LOAD);
    end

    // Frame settings are captured at LOAD so a later store cannot disturb them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_q           <= 1'b1;
            shift_q        <= '0;
            idx_q          <= '0;
            stop_q         <= 1'b0;
            parity_q       <= 1'b0;
            frame_ws_q     <= c_ws_rst;
            frame_par_en_q <= DEF_PAR_EN;
            frame_nstop_q  <= DEF_NSTOP;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    shift_q        <= w_head;
                    parity_q       <= w_parity;
                    idx_q          <= '0;
                    stop_q         <= 1'b0;
                    frame_ws_q     <= cfg_q.ws;
                    frame_par_en_q <= cfg_q.par_en;
                    frame_nstop_q  <= cfg_q.n_stop;
                end
                ST_START: if (i_uart_clk_enable) tx_q <= 1'b0;
                ST_DATA: if (i_uart_clk_enable) begin
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    idx_q   <= idx_q + 1'b1;
                end
                ST_PARITY: if (i_uart_clk_enable) tx_q <= parity_q;
                ST_STOP: if (i_uart_clk_enable) begin
                    tx_q   <= 1'b1;
                    stop_q <= stop_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffered
// Description : Directed self-checking bench for uart_tx_buffered.
// Revision    : 1.0
// ============================================================================
module tb_uart_tx_buffered;

    localparam int DATA_W     = 9;
    localparam int FIFO_DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        cfg;
    logic [DATA_W-1:0] txd;
    logic              txv;
    logic              clr_ovf;
    logic              en;
    logic              tx, ready, busy, ovf;
    logic [4:0]        count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_bits;
    int          exp_len;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_config          (cfg),
        .i_tx_parallel     (txd),
        .i_tx_valid        (txv),
        .i_clear_overflow  (clr_ovf),
        .i_uart_clk_enable (en),
        .o_tx              (tx),
        .o_ready           (ready),
        .o_busy            (busy),
        .o_count           (count),
        .o_overflow        (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] d);
        txv = 1'b1;
        txd = d;
        cyc();
        txv = 1'b0;
    endtask

    task automatic store(input logic [7:0] c);
        cfg = c;
        cyc();
        cfg = 8'h00;
    endtask

    // Expected line levels for one frame, one entry per enable period.
    task automatic build(input logic [8:0] w, input int ws, input bit pen, input bit odd, input bit nstop);
        logic par;
        par      = odd;
        exp_bits = '0;
        exp_len  = 1;
        for (int i = 0; i < ws; i++) begin
            exp_bits[exp_len] = w[i];
            par = par ^ w[i];
            exp_len++;
        end
        if (pen) begin
            exp_bits[exp_len] = par;
            exp_len++;
        end
        exp_bits[exp_len] = 1'b1;
        exp_len++;
        if (nstop) begin
            exp_bits[exp_len] = 1'b1;
            exp_len++;
        end
    endtask

    task automatic run_frame(input string tag, input int exp_cnt);
        for (int i = 0; i < exp_len; i++) begin
            en = 1'b1;
            cyc();
            en = 1'b0;
            chk($sformatf("%s bit%0d", tag, i), 32'(tx), 32'(exp_bits[i]));
            if (i == exp_len - 2)
                chk($sformatf("%s busy_mid", tag), 32'(busy), 32'd1);
            if (i == exp_len - 1) begin
                chk($sformatf("%s busy_end", tag), 32'(busy), 32'd0);
                if (exp_cnt >= 0)
                    chk($sformatf("%s count_end", tag), 32'(count), 32'(exp_cnt));
            end
            repeat (3) cyc();
            chk($sformatf("%s hold%0d", tag, i), 32'(tx), 32'(exp_bits[i]));
        end
    endtask

    function automatic logic [8:0] word(input int k);
        logic [7:0] b;
        b = 8'(k * 37 + 11);
        return {((k % 2) == 1), b};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg = 8'h00; txd = '0; txv = 1'b0; clr_ovf = 1'b0; en = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst tx", 32'(tx), 32'd1);
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);

        // Default config: 8 bits, even parity, 1 stop. Store while busy is ignored.
        push(9'h0A5);
        chk("A count", 32'(count), 32'd1);
        repeat (2) cyc();
        chk("A busy", 32'(busy), 32'd1);
        store(8'h4B);
        build(9'h0A5, 8, 1'b1, 1'b0, 1'b0);
        run_frame("A", 0);

        // Store while idle but FIFO non-empty is ignored too.
        push(9'h1F3);
        store(8'h4B);
        cyc();
        build(9'h1F3, 8, 1'b1, 1'b0, 1'b0);
        run_frame("B", 0);

        // 5-bit word, no parity, 2 stop bits; pushed word masked to 0x13.
        store(8'h4B);
        push(9'h1F3);
        repeat (2) cyc();
        build(9'h013, 5, 1'b0, 1'b0, 1'b1);
        run_frame("C", 0);

        // 8-bit word, parity enabled, odd.
        store(8'hB1);
        push(9'h0FF);
        repeat (2) cyc();
        build(9'h0FF, 8, 1'b1, 1'b1, 1'b0);
        run_frame("D", 0);

        // Word-size field 15 clamps to DATA_W=9.
        store(8'h1F);
        push(9'h155);
        repeat (2) cyc();
        build(9'h155, 9, 1'b0, 1'b0, 1'b0);
        run_frame("E", 0);

        // Word-size field 2 clamps to 5.
        store(8'h05);
        push(9'h0FF);
        repeat (2) cyc();
        build(9'h0FF, 5, 1'b0, 1'b0, 1'b0);
        run_frame("F", 0);

        // Fill: the first word moves into the shifter, so 17 are accepted.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("fill ready%0d", k), 32'(ready), 32'd1);
            txv = 1'b1;
            txd = word(k);
            cyc();
        end
        chk("full ready", 32'(ready), 32'd0);
        chk("full count", 32'(count), 32'd16);
        txd     = 9'h1EE;
        clr_ovf = 1'b1;
        cyc();
        txv     = 1'b0;
        clr_ovf = 1'b0;
        chk("ovf set_wins", 32'(ovf), 32'd1);
        chk("ovf count", 32'(count), 32'd16);
        cyc();
        chk("ovf sticky", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("ovf cleared", 32'(ovf), 32'd0);
        chk("ready after clear", 32'(ready), 32'd0);

        for (int k = 0; k < 17; k++) begin
            build(word(k), 8, 1'b1, 1'b0, 1'b0);
            run_frame($sformatf("drain%0d", k), 16 - k);
        end
        chk("drain busy", 32'(busy), 32'd0);
        chk("drain count", 32'(count), 32'd0);
        chk("drain ready", 32'(ready), 32'd1);

        // Reset in the middle of data bit 3.
        push(9'h000);
        push(9'h000);
        repeat (2) cyc();
        for (int i = 0; i < 4; i++) begin
            en = 1'b1;
            cyc();
            en = 1'b0;
            chk($sformatf("H low%0d", i), 32'(tx), 32'd0);
            repeat (3) cyc();
        end
        chk("H busy", 32'(busy), 32'd1);
        chk("H count", 32'(count), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("H rst tx", 32'(tx), 32'd1);
        chk("H rst count", 32'(count), 32'd0);
        chk("H rst busy", 32'(busy), 32'd0);
        chk("H rst ready", 32'(ready), 32'd1);
        repeat (4) cyc();
        chk("H idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
